// File: rtl/glitch_sequencer.sv
// glitch_sequencer: turns start strobes from the UART command handler into a
// delayed train of glitch pulses, optionally preceded by a target reset or
// gated by an external trigger edge.
// Optional build macro: GLITCH_TIMEOUT_EN adds an armed-state timeout that
// returns to IDLE and strobes timeout_o when no trigger edge arrives.
module glitch_sequencer #(
  parameter bit          TRIG_RISING = 1'b1,
  parameter int unsigned TIMEOUT_W   = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] pulse_spacing_i,
  input  logic [15:0] reset_length_i,
  input  logic        pulse_en_i,
  input  logic        reset_en_i,
  input  logic        arm_i,
  input  logic        trigger_i,
  output logic        glitch_o,
  output logic        target_reset_o,
  output logic        armed_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    ARMED,
    DELAY,
    PULSE,
    SPACE
  } state_t;

  // Zero-valued lengths behave as one cycle; returns the reload for a
  // down-counter that ends its phase when it reads zero.
  function automatic logic [15:0] last_count(input logic [15:0] len);
    return (len == 16'd0) ? 16'd0 : len - 16'd1;
  endfunction

  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
    $error("TIMEOUT_W must be at least 1");
  end

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  pulse_cnt, pulse_cnt_n;
  logic [15:0] sh_delay, sh_delay_n;
  logic [7:0]  sh_width, sh_width_n;
  logic [7:0]  sh_num, sh_num_n;
  logic [15:0] sh_space, sh_space_n;
  logic        glitch_n, target_reset_n, done_n;
  logic [7:0]  num_eff;

  // Trigger synchronizer and edge-detect stage.
  logic sync1, sync2, sync3;
  logic trig_edge;

`ifdef GLITCH_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt, tcnt_n;
  logic                 timeout_n;
`endif

  // Bring the asynchronous trigger into the clock domain and keep one
  // extra stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its neighbour, which is what makes this a shift chain.
      sync1 <= trigger_i;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign trig_edge = TRIG_RISING ? (sync2 & ~sync3) : (~sync2 & sync3);
  assign num_eff   = (sh_num == 8'd0) ? 8'd1 : sh_num;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_n        = state;
    cnt_n          = cnt;
    pulse_cnt_n    = pulse_cnt;
    sh_delay_n     = sh_delay;
    sh_width_n     = sh_width;
    sh_num_n       = sh_num;
    sh_space_n     = sh_space;
    glitch_n       = glitch_o;
    target_reset_n = target_reset_o;
    done_n         = 1'b0;
`ifdef GLITCH_TIMEOUT_EN
    tcnt_n         = tcnt;
    timeout_n      = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        if (reset_en_i || pulse_en_i || arm_i) begin
          // Reset length is consumed right here, so it needs no shadow copy.
          sh_delay_n  = delay_i;
          sh_width_n  = width_i;
          sh_num_n    = num_pulses_i;
          sh_space_n  = pulse_spacing_i;
          pulse_cnt_n = 8'd0;
        end
        if (reset_en_i) begin
          state_n        = RESET;
          target_reset_n = 1'b1;
          cnt_n          = last_count(reset_length_i);
        end else if (pulse_en_i) begin
          state_n = DELAY;
          cnt_n   = delay_i;
        end else if (arm_i) begin
          state_n = ARMED;
`ifdef GLITCH_TIMEOUT_EN
          tcnt_n  = '0;
`endif
        end
      end

      RESET: begin
        if (cnt == 16'd0) begin
          state_n        = DELAY;
          target_reset_n = 1'b0;
          cnt_n          = sh_delay;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end

      ARMED: begin
        if (trig_edge) begin
          state_n = DELAY;
          cnt_n   = sh_delay;
        end
`ifdef GLITCH_TIMEOUT_EN
        else if (&tcnt) begin
          state_n   = IDLE;
          timeout_n = 1'b1;
        end else begin
          tcnt_n = tcnt + TIMEOUT_W'(1);
        end
`endif
      end

      DELAY: begin
        if (cnt == 16'd0) begin
          state_n     = PULSE;
          glitch_n    = 1'b1;
          cnt_n       = last_count({8'd0, sh_width});
          pulse_cnt_n = 8'd1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end

      PULSE: begin
        if (cnt == 16'd0) begin
          glitch_n = 1'b0;
          if (pulse_cnt < num_eff) begin
            state_n = SPACE;
            cnt_n   = last_count(sh_space);
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end

      SPACE: begin
        if (cnt == 16'd0) begin
          state_n     = PULSE;
          glitch_n    = 1'b1;
          cnt_n       = last_count({8'd0, sh_width});
          pulse_cnt_n = pulse_cnt + 8'd1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State, counters, shadow configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 16'd0;
      pulse_cnt      <= 8'd0;
      sh_delay       <= 16'd0;
      sh_width       <= 8'd0;
      sh_num         <= 8'd0;
      sh_space       <= 16'd0;
      glitch_o       <= 1'b0;
      target_reset_o <= 1'b0;
      armed_o        <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      pulse_cnt      <= pulse_cnt_n;
      sh_delay       <= sh_delay_n;
      sh_width       <= sh_width_n;
      sh_num         <= sh_num_n;
      sh_space       <= sh_space_n;
      glitch_o       <= glitch_n;
      target_reset_o <= target_reset_n;
      armed_o        <= (state_n == ARMED);
      busy_o         <= (state_n != IDLE);
      done_o         <= done_n;
    end
  end

`ifdef GLITCH_TIMEOUT_EN
  // Armed-state timeout counter and its completion strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      timeout_o <= 1'b0;
    end else begin
      tcnt      <= tcnt_n;
      timeout_o <= timeout_n;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule
